// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Master ids, lane count and the read-tracking entry.
package dmem_pkg;

    localparam int   NUM_LANES = 4;
    localparam logic M0_ID     = 1'b0;
    localparam logic M1_ID     = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_entry_t;

endpackage

// File: rtl/rd_tracker.sv
// Fixed-depth shift register that follows each accepted read
// down the BRAM pipeline so its data returns to the issuing master.
import dmem_pkg::*;

module rd_tracker #(
    parameter int RD_LATENCY = 1
) (
    input  logic      clk,
    input  logic      reset,
    input  rd_entry_t push_entry,
    output rd_entry_t head_entry
);

    rd_entry_t stages [RD_LATENCY];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= push_entry;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign head_entry = stages[RD_LATENCY-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing BRAM port A between the CPU (M0)
// and the loader (M1), returning read data to the issuing master.
import dmem_pkg::*;

module dmem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 1,
    parameter int DATA_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m0_req_i,
    input  logic [NUM_LANES-1:0] m0_we_i,
    input  logic [31:0]          m0_addr_i,
    input  logic [DATA_W-1:0]    m0_wdata_i,
    output logic                 m0_gnt_o,
    output logic                 m0_rvalid_o,
    output logic [DATA_W-1:0]    m0_rdata_o,
    input  logic                 m1_req_i,
    input  logic [NUM_LANES-1:0] m1_we_i,
    input  logic [31:0]          m1_addr_i,
    input  logic [DATA_W-1:0]    m1_wdata_i,
    output logic                 m1_gnt_o,
    output logic                 m1_rvalid_o,
    output logic [DATA_W-1:0]    m1_rdata_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [NUM_LANES-1:0] mem_we_o,
    output logic [DATA_W-1:0]    mem_din_o,
    input  logic [DATA_W-1:0]    mem_dout_i
);

    logic      last_grant;
    logic      gnt0;
    logic      gnt1;
    rd_entry_t push_entry;
    rd_entry_t head_entry;
    logic      unused_addr;

    // Contention goes to whichever master did not win last time.
    always_comb begin
        gnt0 = reset && m0_req_i && (!m1_req_i || last_grant == M1_ID);
        gnt1 = reset && m1_req_i && (!m0_req_i || last_grant == M0_ID);
    end

    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= M1_ID;
        end else if (gnt0) begin
            last_grant <= M0_ID;
        end else if (gnt1) begin
            last_grant <= M1_ID;
        end
    end

    always_comb begin
        mem_addr_o = '0;
        mem_we_o   = '0;
        mem_din_o  = '0;
        unique case (1'b1)
            gnt0: begin
                mem_addr_o = m0_addr_i[ADDR_W+1:2];
                mem_we_o   = m0_we_i;
                mem_din_o  = m0_wdata_i;
            end
            gnt1: begin
                mem_addr_o = m1_addr_i[ADDR_W+1:2];
                mem_we_o   = m1_we_i;
                mem_din_o  = m1_wdata_i;
            end
            default: ;
        endcase
    end

    assign unused_addr = ^{m0_addr_i[31:ADDR_W+2], m0_addr_i[1:0],
                           m1_addr_i[31:ADDR_W+2], m1_addr_i[1:0]};

    always_comb begin
        push_entry       = '0;
        push_entry.valid = (gnt0 && m0_we_i == '0) ||
                           (gnt1 && m1_we_i == '0);
        push_entry.id    = gnt1 ? M1_ID : M0_ID;
    end

    rd_tracker #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_tracker (
        .clk        (clk),
        .reset      (reset),
        .push_entry (push_entry),
        .head_entry (head_entry)
    );

    always_comb begin
        m0_rvalid_o = head_entry.valid && head_entry.id == M0_ID;
        m1_rvalid_o = head_entry.valid && head_entry.id == M1_ID;
        m0_rdata_o  = m0_rvalid_o ? mem_dout_i : '0;
        m1_rdata_o  = m1_rvalid_o ? mem_dout_i : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter, driving a latency-1 and a
// latency-2 instance in lockstep against behavioural BRAM models.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [3:0]  m0_we = '0, m1_we = '0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;

    logic        a_g0, a_g1, a_rv0, a_rv1;
    logic [31:0] a_rd0, a_rd1, a_din;
    logic [9:0]  a_addr;
    logic [3:0]  a_we;
    logic        b_g0, b_g1, b_rv0, b_rv1;
    logic [31:0] b_rd0, b_rd1, b_din;
    logic [9:0]  b_addr;
    logic [3:0]  b_we;

    logic [31:0] mem1 [1024];
    logic [31:0] mem2 [1024];
    logic [31:0] dout1 = '0, dout2 = '0, r2 = '0;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dmem_arbiter #(.ADDR_W(10), .RD_LATENCY(1), .DATA_W(32)) u_lat1 (
        .clk(clk), .reset(reset),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(a_g0), .m0_rvalid_o(a_rv0),
        .m0_rdata_o(a_rd0),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(a_g1), .m1_rvalid_o(a_rv1),
        .m1_rdata_o(a_rd1),
        .mem_addr_o(a_addr), .mem_we_o(a_we), .mem_din_o(a_din),
        .mem_dout_i(dout1)
    );

    dmem_arbiter #(.ADDR_W(10), .RD_LATENCY(2), .DATA_W(32)) u_lat2 (
        .clk(clk), .reset(reset),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(b_g0), .m0_rvalid_o(b_rv0),
        .m0_rdata_o(b_rd0),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(b_g1), .m1_rvalid_o(b_rv1),
        .m1_rdata_o(b_rd1),
        .mem_addr_o(b_addr), .mem_we_o(b_we), .mem_din_o(b_din),
        .mem_dout_i(dout2)
    );

    // BRAM models: read-before-write, 1 and 2 cycle read latency.
    always @(posedge clk) begin
        dout1 = mem1[a_addr];
        for (int i = 0; i < 4; i++)
            if (a_we[i]) mem1[a_addr][8*i +: 8] = a_din[8*i +: 8];
        dout2 = r2;
        r2 = mem2[b_addr];
        for (int i = 0; i < 4; i++)
            if (b_we[i]) mem2[b_addr][8*i +: 8] = b_din[8*i +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_rsp(input string tag, input logic rv0, rv1,
                             input logic [31:0] rd0, rd1, input exp_t e);
        chk({tag, " rvalid"}, {30'd0, rv1, rv0}, e.id ? 32'd2 : 32'd1);
        chk({tag, " rdata"}, e.id ? rd1 : rd0, e.data);
        chk({tag, " idle rdata"}, e.id ? rd0 : rd1, 32'd0);
        chk({tag, " cycle"}, cyc, e.due);
    endtask

    always @(negedge clk) begin
        while (q1.size() > 0 && q1[0].due < cyc) begin
            chk("lat1 rvalid missing at due", cyc, q1[0].due);
            void'(q1.pop_front());
        end
        if (a_rv0 || a_rv1) begin
            if (q1.size() == 0) chk("lat1 unexpected rvalid", {a_rv1, a_rv0}, 0);
            else check_rsp("lat1", a_rv0, a_rv1, a_rd0, a_rd1, q1.pop_front());
        end
        while (q2.size() > 0 && q2[0].due < cyc) begin
            chk("lat2 rvalid missing at due", cyc, q2[0].due);
            void'(q2.pop_front());
        end
        if (b_rv0 || b_rv1) begin
            if (q2.size() == 0) chk("lat2 unexpected rvalid", {b_rv1, b_rv0}, 0);
            else check_rsp("lat2", b_rv0, b_rv1, b_rd0, b_rd1, q2.pop_front());
        end
    end

    task automatic step(
        input logic r0, input logic [3:0] w0, input logic [31:0] a0, d0,
        input logic r1, input logic [3:0] w1, input logic [31:0] a1, d1,
        input logic eg0, eg1, input logic [9:0] eaddr,
        input logic [3:0] ewe, input logic push, input logic [31:0] erd);
        logic [31:0] edin;
        @(negedge clk);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        #1;
        edin = eg0 ? d0 : (eg1 ? d1 : 32'd0);
        chk("gnt0", a_g0, eg0);
        chk("gnt1", a_g1, eg1);
        chk("lat2 gnt", {b_g0, b_g1}, {eg0, eg1});
        chk("mem_addr", a_addr, eaddr);
        chk("mem_we", a_we, ewe);
        chk("mem_din", a_din, edin);
        if (push) begin
            q1.push_back('{eg1, erd, cyc + 1});
            q2.push_back('{eg1, erd, cyc + 2});
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = '0;
            mem2[i] = '0;
        end
        mem1[4] = 32'hDEADBEEF; mem2[4] = 32'hDEADBEEF;
        mem1[1] = 32'h11111111; mem2[1] = 32'h11111111;

        // Reset state with both masters requesting.
        m0_req = 1'b1; m0_addr = 32'h10; m1_req = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("reset gnt0", a_g0, 0);
        chk("reset gnt1", a_g1, 0);
        chk("reset mem_we", a_we, 0);
        chk("reset mem_addr", a_addr, 0);
        chk("reset mem_din", a_din, 0);
        chk("reset rvalid", {a_rv0, a_rv1, b_rv0, b_rv1}, 0);
        chk("reset rdata", a_rd0 | a_rd1, 0);
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Read accepted just before reset must be dropped.
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, 10'd4, 0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        chk("midreset gnt0", a_g0, 0);
        chk("midreset rvalid", {a_rv0, a_rv1, b_rv0, b_rv1}, 0);
        m0_req = 1'b0;
        reset = 1'b1;

        // First contention after reset goes to M0.
        step(1, 0, 32'h10, 0, 1, 0, 32'h0, 0, 1, 0, 10'd4, 0, 1, 32'hDEADBEEF);
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, 10'd4, 0, 1, 32'hDEADBEEF);
        // M1 partial write, then M0 reads it back.
        step(0, 0, 0, 0, 1, 4'b0011, 32'h23, 32'h0000ABCD,
             0, 1, 10'd8, 4'b0011, 0, 0);
        step(1, 0, 32'h20, 0, 0, 0, 0, 0, 1, 0, 10'd8, 0, 1, 32'h0000ABCD);
        // Address wrap: 0x1004 maps to word 1.
        step(0, 0, 0, 0, 1, 0, 32'h1004, 0, 0, 1, 10'd1, 0, 1, 32'h11111111);
        // Continuous contention alternates, starting with M0.
        for (int i = 0; i < 6; i++) begin
            logic ev;
            ev = (i % 2 == 0);
            step(1, 0, 32'h10, 0, 1, 0, 32'h4, 0, ev, !ev,
                 ev ? 10'd4 : 10'd1, 0, 1, ev ? 32'hDEADBEEF : 32'h11111111);
        end
        // Idle: no grant, outputs parked.
        step(0, 0, 0, 0, 0, 4'hF, 32'h8, 32'h55, 0, 0, 10'd0, 0, 0, 0);
        step(1, 4'hF, 32'h3C, 32'h12345678, 0, 4'h3, 32'h8, 32'h77,
             1, 0, 10'd15, 4'hF, 0, 0);
        step(1, 0, 32'h3C, 0, 1, 4'b1100, 32'h8, 32'hBEEF0000,
             0, 1, 10'd2, 4'b1100, 0, 0);
        step(1, 0, 32'h3C, 0, 0, 0, 0, 0, 1, 0, 10'd15, 0, 1, 32'h12345678);
        step(0, 0, 0, 0, 1, 0, 32'h8, 0, 0, 1, 10'd2, 0, 1, 32'hBEEF0000);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'd0, 0, 0, 0);
        chk("lat1 queue drained", q1.size(), 0);
        chk("lat2 queue drained", q2.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
